// File: rtl/sgmii_pkg.sv
// Shared definitions for the S/GMII rate adaptation blocks.
// Holds rate encodings, replication divisors, read-scheduler state
// encodings and symbol field positions. No ports.
package sgmii_pkg;

  localparam logic [1:0] RATE_10   = 2'b00;
  localparam logic [1:0] RATE_100  = 2'b01;
  localparam logic [1:0] RATE_1000 = 2'b10;

  // Replication factor per rate (cycles per symbol).
  localparam logic [6:0] DIV_10   = 7'd100;
  localparam logic [6:0] DIV_100  = 7'd10;
  localparam logic [6:0] DIV_1000 = 7'd1;

  localparam int SYM_W     = 9;
  localparam int VALID_BIT = 8;
  localparam int DATA_MSB  = 7;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Terminal divider count for a rate; 2'b11 is treated as 1000M.
  function automatic logic [6:0] div_last(input logic [1:0] r);
    logic [6:0] last;
    case (r)
      RATE_10:   last = DIV_10 - 7'd1;
      RATE_100:  last = DIV_100 - 7'd1;
      RATE_1000: last = DIV_1000 - 7'd1;
      default:   last = DIV_1000 - 7'd1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/sgmii_rate_pop_if.sv
// Symbol path between the async FIFO read port and the transmit encoder.
// fifo_out/empty : show-ahead FIFO head word and empty flag
// pop            : advances the FIFO tail
// data_out       : symbol presented to the encoder
// data_stb       : 1 on cycles where data_out takes a new symbol
// master = rate scheduler, slave = FIFO + encoder side.
interface sgmii_rate_pop_if;
  import sgmii_pkg::*;

  logic [SYM_W-1:0] fifo_out;
  logic             empty;
  logic             pop;
  logic [SYM_W-1:0] data_out;
  logic             data_stb;

  modport master (input fifo_out, input empty, output pop, output data_out, output data_stb);
  modport slave  (output fifo_out, output empty, input pop, input data_out, input data_stb);
endinterface

// File: rtl/sgmii_rate_div.sv
// Symbol-rate divider: counts 0..N-1 with N taken from the rate in force
// and flags tick on count 0.
// clk, rst_n : clock, async active-low reset
// rate_q     : rate in force (selects N = 1/10/100)
// clr        : synchronous restart of the count at 0
// tick       : 1 when the count is 0
module sgmii_rate_div
  import sgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rate_q,
  input  logic       clr,
  output logic       tick
);

  logic [6:0] div;

  // Free-running modulo-N counter; >= guards against a count left over from a slower rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= 7'd0;
    end else if (clr) begin
      div <= 7'd0;
    end else if (div >= div_last(rate_q)) begin
      div <= 7'd0;
    end else begin
      div <= div + 7'd1;
    end
  end

  assign tick = (div == 7'd0);

endmodule

// File: rtl/sgmii_rate_pop.sv
// Read-side scheduler for the S/GMII cycle async FIFO. Pops one symbol per
// divider tick so each symbol is replicated 1/10/100 times, primes the FIFO
// before streaming and discards the tail of a frame that underran.
// clk, rst_n   : FIFO output clock, async active-low reset
// enable       : 0 forces FILL and idle output
// rate         : requested rate (00=10M, 01=100M, 1x=1000M)
// bus          : FIFO head/empty/pop and encoder data_out/data_stb
// rate_q       : rate in force
// underrun     : one-cycle pulse on mid-frame underrun
// underrun_cnt : saturating underrun count
module sgmii_rate_pop
  import sgmii_pkg::*;
#(
  parameter int PRIME_CNT = 4,
  parameter int UCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        rate,
  sgmii_rate_pop_if.master  bus,
  output logic [1:0]        rate_q,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam logic [3:0] PRIME_TGT = PRIME_CNT[3:0];

  state_t           state;
  state_t           nxt_state;
  logic [3:0]       prime;
  logic             last_valid;
  logic             tick;
  logic             pop_int;
  logic             load;
  logic [SYM_W-1:0] load_val;
  logic             under_hit;
  logic             run_start;
  logic             rate_ld;
  logic             rate_change;
  logic [SYM_W-1:0] out_sym;
  logic             out_stb;

  // A new rate is accepted only where no frame symbol is being emitted.
  assign rate_change = rate_ld && (rate != rate_q);

  sgmii_rate_div u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .rate_q (rate_q),
    .clr    (run_start | rate_change),
    .tick   (tick)
  );

  // Next-state, pop and symbol-load decisions.
  always_comb begin
    nxt_state = state;
    pop_int   = 1'b0;
    load      = 1'b0;
    load_val  = {SYM_W{1'b0}};
    under_hit = 1'b0;
    run_start = 1'b0;
    rate_ld   = 1'b0;
    case (state)
      FILL: begin
        rate_ld = 1'b1;
        load    = tick;
        if (enable && (prime == PRIME_TGT)) begin
          nxt_state = RUN;
          run_start = 1'b1;
        end else begin
          nxt_state = FILL;
        end
      end
      RUN: begin
        if (!enable) begin
          nxt_state = FILL;
          load      = tick;
        end else if (tick) begin
          load = 1'b1;
          if (!bus.empty) begin
            pop_int  = 1'b1;
            load_val = {bus.fifo_out[VALID_BIT], bus.fifo_out[DATA_MSB:0]};
          end else if (last_valid) begin
            under_hit = 1'b1;
            nxt_state = DROP;
          end else begin
            nxt_state = RUN;
          end
          rate_ld = ~load_val[VALID_BIT];
        end else begin
          nxt_state = RUN;
        end
      end
      DROP: begin
        load = tick;
        if (!enable) begin
          nxt_state = FILL;
        end else if (!bus.empty) begin
          // Discard in-frame words at full clock rate; the first idle word is kept.
          if (bus.fifo_out[VALID_BIT]) begin
            pop_int = 1'b1;
          end else begin
            nxt_state = FILL;
          end
        end else begin
          nxt_state = DROP;
        end
      end
      default: begin
        nxt_state = FILL;
        load      = tick;
      end
    endcase
  end

  // State, prime counter and frame-in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      prime      <= 4'd0;
      last_valid <= 1'b0;
    end else begin
      state <= nxt_state;
      if ((state != FILL) || !enable || bus.empty) begin
        prime <= 4'd0;
      end else if (prime != PRIME_TGT) begin
        prime <= prime + 4'd1;
      end else begin
        prime <= prime;
      end
      if (pop_int && (state == RUN)) begin
        last_valid <= bus.fifo_out[VALID_BIT];
      end else if (nxt_state != RUN) begin
        last_valid <= 1'b0;
      end else begin
        last_valid <= last_valid;
      end
    end
  end

  // Registered symbol path, rate in force and underrun reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sym      <= {SYM_W{1'b0}};
      out_stb      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= {UCNT_W{1'b0}};
      rate_q       <= RATE_1000;
    end else begin
      if (load) begin
        out_sym <= load_val;
      end
      out_stb  <= tick;
      underrun <= under_hit;
      if (under_hit && (underrun_cnt != {UCNT_W{1'b1}})) begin
        underrun_cnt <= underrun_cnt + UCNT_W'(1);
      end
      if (rate_ld) begin
        rate_q <= rate;
      end
    end
  end

  assign bus.pop      = pop_int;
  assign bus.data_out = out_sym;
  assign bus.data_stb = out_stb;

endmodule

// File: tb/tb_sgmii_rate_pop.sv
// Directed self-checking bench for sgmii_rate_pop with a queue-based FIFO
// model and a scoreboard of the symbols expected on data_out.
module tb_sgmii_rate_pop;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  rate;
  logic [1:0]  rate_q;
  logic        underrun;
  logic [15:0] underrun_cnt;

  sgmii_rate_pop_if bus();

  sgmii_rate_pop #(.PRIME_CNT(4), .UCNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rate         (rate),
    .bus          (bus.master),
    .rate_q       (rate_q),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  logic [8:0] fq[$];        // FIFO contents
  logic [8:0] exp_q[$];     // symbols expected on data_out, in order
  logic [8:0] exp_drop[$];  // words expected to be popped and discarded
  logic [8:0] popped_w;
  logic [8:0] prev_do;
  bit         popped;
  bit         drop_mode;
  bit         hold_chk;
  int         cyc_n;
  int         pop_total;
  int         under_total;
  int         stb_total;
  int         errors;
  int         checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive FIFO model, sample pop, then check registered outputs.
  task automatic cyc();
    bus.empty    = (fq.size() == 0);
    bus.fifo_out = (fq.size() == 0) ? 9'd0 : fq[0];
    #2;
    popped = bus.pop;
    chk("pop_when_empty", 32'(bus.pop & bus.empty), 32'd0);
    if (popped && (fq.size() > 0)) popped_w = fq.pop_front();
    @(posedge clk);
    #1;
    cyc_n++;
    if (popped) pop_total++;
    if (underrun) under_total++;
    if (bus.data_stb) stb_total++;
    if (popped && drop_mode) begin
      checks++;
      assert (exp_drop.size() != 0) else begin
        errors++;
        $error("FAIL drop_extra observed=%0h expected=no pop", popped_w);
      end
      if (exp_drop.size() != 0) chk("drop_word", 32'(popped_w), 32'(exp_drop.pop_front()));
      chk("drop_data_out", 32'(bus.data_out), 32'd0);
    end else if (popped) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra observed=%0h expected=no pop", popped_w);
      end
      if (exp_q.size() != 0) chk("data_out", 32'(bus.data_out), 32'(exp_q.pop_front()));
    end
    if (hold_chk) begin
      if (!popped) chk("data_hold", 32'(bus.data_out), 32'(prev_do));
      chk("stb_vs_pop", 32'(bus.data_stb), 32'(popped));
    end
    prev_do = bus.data_out;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Run until the DUT pops; an expired budget is a failed check.
  task automatic wait_pop(input string tag, input int budget, output int at);
    int n;
    cyc();
    n = 1;
    while (!popped && (n < budget)) begin
      cyc();
      n++;
    end
    checks++;
    assert (popped) else begin
      errors++;
      $error("FAIL %s observed=no pop expected=pop within %0d cycles", tag, budget);
    end
    at = cyc_n;
  endtask

  task automatic push_frame(input bit also_exp);
    for (int i = 0; i < 8; i++) begin
      fq.push_back(9'h155 + 9'(i));
      if (also_exp) exp_q.push_back(9'h155 + 9'(i));
    end
    fq.push_back(9'h000);
    if (also_exp) exp_q.push_back(9'h000);
  endtask

  initial begin
    int at, prev, start, pops0, und0;
    errors = 0; checks = 0; cyc_n = 0; pop_total = 0; under_total = 0; stb_total = 0;
    drop_mode = 1'b0; hold_chk = 1'b0; prev_do = 9'd0; popped_w = 9'd0;
    rst_n = 1'b0; enable = 1'b0; rate = 2'b00;
    bus.empty = 1'b1; bus.fifo_out = 9'd0;

    // Reset values (rate input differs from reset value of rate_q)
    cycles(3);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_data_stb", 32'(bus.data_stb), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
    chk("rst_rate_q", 32'(rate_q), 32'd2);
    chk("rst_pop", 32'(popped), 32'd0);
    rst_n = 1'b1; rate = 2'b10; enable = 1'b1;
    cycles(3);
    chk("fill_rate_q", 32'(rate_q), 32'd2);

    // 1000M stream: pop 5 cycles after empty falls, one word per cycle
    pop_total = 0;
    push_frame(1'b1);
    start = cyc_n + 1;
    wait_pop("t1_first_pop", 20, at);
    chk("t1_prime_delay", 32'(at - start), 32'd5);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t1_stb_1000", 32'(bus.data_stb), 32'd1);
      chk("t1_pop_each", 32'(popped), 32'd1);
    end
    chk("t1_pops", 32'(pop_total), 32'd9);
    chk("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Inter-frame empty: idle zeros, no underrun, no re-prime
    cycles(5);
    chk("t5_idle_data", 32'(bus.data_out), 32'd0);
    chk("t5_no_pop", 32'(pop_total), 32'd9);
    chk("t5_no_underrun", 32'(under_total), 32'd0);
    fq.push_back(9'h1AA); exp_q.push_back(9'h1AA);
    fq.push_back(9'h000); exp_q.push_back(9'h000);
    start = cyc_n + 1;
    wait_pop("t5_pop", 5, at);
    chk("t5_no_reprime", 32'(at - start), 32'd0);
    cycles(3);
    chk("t5_pops", 32'(pop_total), 32'd11);
    chk("t5_underrun_cnt", 32'(underrun_cnt), 32'd0);

    // 100M replication: 10 cycles per word
    enable = 1'b0; rate = 2'b01;
    cycles(2);
    chk("t2_rate_q", 32'(rate_q), 32'd1);
    enable = 1'b1;
    cycles(1);
    push_frame(1'b1);
    start = cyc_n + 1;
    wait_pop("t2_first_pop", 30, at);
    chk("t2_prime_delay", 32'(at - start), 32'd5);
    stb_total = 0; hold_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prev = at;
      wait_pop("t2_pop", 20, at);
      chk("t2_pop_interval", 32'(at - prev), 32'd10);
    end
    hold_chk = 1'b0;
    chk("t2_stb_count", 32'(stb_total), 32'd8);
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);

    // Mid-frame underrun at 1000M
    enable = 1'b0; rate = 2'b10;
    cycles(2);
    enable = 1'b1;
    fq.push_back(9'h155); exp_q.push_back(9'h155);
    fq.push_back(9'h156); exp_q.push_back(9'h156);
    wait_pop("t3_pop0", 20, at);
    wait_pop("t3_pop1", 3, at);
    cyc();
    chk("t3_underrun", 32'(underrun), 32'd1);
    chk("t3_ucnt", 32'(underrun_cnt), 32'd1);
    chk("t3_data_zero", 32'(bus.data_out), 32'd0);
    drop_mode = 1'b1;
    pops0 = pop_total;
    cycles(3);
    chk("t3_pulse_once", 32'(underrun), 32'd0);
    chk("t3_wait_empty", 32'(pop_total), 32'(pops0));
    fq.push_back(9'h157); exp_drop.push_back(9'h157);
    fq.push_back(9'h158); exp_drop.push_back(9'h158);
    fq.push_back(9'h000);
    cycles(3);
    chk("t3_kept_word", 32'(fq.size()), 32'd1);
    chk("t3_drop_done", 32'(exp_drop.size()), 32'd0);
    drop_mode = 1'b0;
    pops0 = pop_total;
    cycles(4);
    chk("t3_fill_no_pop", 32'(pop_total), 32'(pops0));
    chk("t3_under_total", 32'(under_total), 32'd1);
    exp_q.push_back(9'h000);
    wait_pop("t3_refill_pop", 10, at);
    chk("t3_ucnt_final", 32'(underrun_cnt), 32'd1);

    // Rate change 1000M -> 10M mid-frame
    push_frame(1'b1);
    fq.push_back(9'h1AA); exp_q.push_back(9'h1AA);
    fq.push_back(9'h1BB); exp_q.push_back(9'h1BB);
    fq.push_back(9'h000); exp_q.push_back(9'h000);
    wait_pop("t4_first", 5, at);
    rate = 2'b00;
    for (int i = 0; i < 7; i++) begin
      wait_pop("t4_frame", 3, at);
      chk("t4_rate_held", 32'(rate_q), 32'd2);
    end
    wait_pop("t4_idle_word", 3, at);
    chk("t4_rate_switch", 32'(rate_q), 32'd0);
    prev = at;
    wait_pop("t4_next_frame", 3, at);
    chk("t4_restart_tick", 32'(at - prev), 32'd1);
    prev = at;
    wait_pop("t4_10m_a", 150, at);
    chk("t4_interval_a", 32'(at - prev), 32'd100);
    chk("t4_rate_10m", 32'(rate_q), 32'd0);
    prev = at;
    wait_pop("t4_10m_b", 150, at);
    chk("t4_interval_b", 32'(at - prev), 32'd100);

    // Async reset mid-frame at 10M
    fq.push_back(9'h1CC); exp_q.push_back(9'h1CC);
    fq.push_back(9'h1DD);
    wait_pop("t6_pop_1cc", 120, at);
    cycles(5);
    chk("t6_pre_data", 32'(bus.data_out), 32'h1CC);
    rst_n = 1'b0;
    #1;
    chk("t6_async_data", 32'(bus.data_out), 32'd0);
    chk("t6_async_stb", 32'(bus.data_stb), 32'd0);
    chk("t6_async_rate_q", 32'(rate_q), 32'd2);
    chk("t6_async_ucnt", 32'(underrun_cnt), 32'd0);
    chk("t6_async_pop", 32'(bus.pop), 32'd0);
    cycles(2);
    chk("t6_rst_pop", 32'(popped), 32'd0);

    // enable=0 mid-frame: FILL, no pop, no underrun, re-prime on re-enable
    rate = 2'b10; rst_n = 1'b1; enable = 1'b1;
    fq.push_back(9'h1EE);
    exp_q.push_back(9'h1DD);
    wait_pop("t6_pop_1dd", 20, at);
    enable = 1'b0;
    und0 = under_total;
    pops0 = pop_total;
    cycles(5);
    chk("t6_en_no_pop", 32'(pop_total), 32'(pops0));
    chk("t6_en_no_under", 32'(under_total), 32'(und0));
    chk("t6_en_ucnt", 32'(underrun_cnt), 32'd0);
    chk("t6_en_data", 32'(bus.data_out), 32'd0);
    enable = 1'b1;
    exp_q.push_back(9'h1EE);
    fq.push_back(9'h000); exp_q.push_back(9'h000);
    start = cyc_n + 1;
    wait_pop("t6_reprime", 20, at);
    chk("t6_reprime_delay", 32'(at - start), 32'd5);
    wait_pop("t6_end", 3, at);
    cycles(3);
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("end_under_total", 32'(under_total), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
